// File: rtl/window_min_hold_pkg.sv
// Shared definitions for the AD-path windowed min/max trackers.
// Holds the sample width, default window length and the tracker FSM encoding.
package window_min_hold_pkg;

  localparam int AD_DATA_W             = 9;
  localparam int DEFAULT_WINDOW_CYCLES = 6266880;

  // 1-bit tracker FSM encoding, shared with the max tracker rewrite
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

endpackage

// File: rtl/window_timer.sv
// Window cycle counter: counts 0..WINDOW_CYCLES-1 while enabled and wraps.
// The last flag marks the final cycle of the current window.
module window_timer #(
  parameter int WINDOW_CYCLES = 8,
  parameter int CNT_W         = 32
) (
  input  logic clock,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] cnt_r;

  assign last = (cnt_r == CNT_W'(WINDOW_CYCLES - 1));

  // Counter register: clear wins, then wrap on the last cycle, else count.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      if (last) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/window_min_hold.sv
// Windowed minimum tracker for the AD sample stream. Publishes the minimum of
// each completed window as a held value with a one-cycle valid strobe.
module window_min_hold
  import window_min_hold_pkg::*;
#(
  parameter int DATA_W        = AD_DATA_W,
  parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
  parameter int CNT_W         = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_vld,
  output logic [DATA_W-1:0] run_min,
  output logic [DATA_W-1:0] min_out,
  output logic              min_vld,
  output logic              min_empty
);

  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

  logic [0:0]        state_r;
  logic [0:0]        state_nxt;
  logic [DATA_W-1:0] run_min_r;
  logic [DATA_W-1:0] run_min_nxt;
  logic              has_smp_r;
  logic              has_smp_nxt;
  logic [DATA_W-1:0] min_out_r;
  logic [DATA_W-1:0] min_out_nxt;
  logic              min_vld_r;
  logic              min_vld_nxt;
  logic              min_empty_r;
  logic              min_empty_nxt;

  logic              track_s;
  logic              last_s;
  logic              take_s;
  logic [DATA_W-1:0] eff_s;

  assign track_s = (state_r == ST_TRACK) && enable;

  window_timer #(
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clock  (clock),
    .rst_n  (rst_n),
    .clear  (!track_s),
    .enable (track_s),
    .last   (last_s)
  );

  // Same-cycle compare: a sample on the last cycle still counts toward the window
  assign take_s = sample_vld && (sample_in < run_min_r);
  assign eff_s  = take_s ? sample_in : run_min_r;

  // Next-state and datapath update for the IDLE/TRACK tracker.
  always_comb begin
    state_nxt     = state_r;
    run_min_nxt   = run_min_r;
    has_smp_nxt   = has_smp_r;
    min_out_nxt   = min_out_r;
    min_empty_nxt = min_empty_r;
    min_vld_nxt   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nxt   = ST_TRACK;
          run_min_nxt = ALL_ONES;
          has_smp_nxt = 1'b0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_TRACK: begin
        if (!enable) begin
          // Partial window is dropped without a strobe
          state_nxt   = ST_IDLE;
          run_min_nxt = ALL_ONES;
          has_smp_nxt = 1'b0;
        end else if (last_s) begin
          min_vld_nxt = 1'b1;
          run_min_nxt = ALL_ONES;
          has_smp_nxt = 1'b0;
          if (has_smp_r || sample_vld) begin
            min_out_nxt   = eff_s;
            min_empty_nxt = 1'b0;
          end else begin
            min_empty_nxt = 1'b1;
          end
        end else begin
          run_min_nxt = eff_s;
          has_smp_nxt = has_smp_r | sample_vld;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        run_min_nxt = ALL_ONES;
        has_smp_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      run_min_r   <= ALL_ONES;
      has_smp_r   <= 1'b0;
      min_out_r   <= {DATA_W{1'b0}};
      min_vld_r   <= 1'b0;
      min_empty_r <= 1'b1;
    end else begin
      state_r     <= state_nxt;
      run_min_r   <= run_min_nxt;
      has_smp_r   <= has_smp_nxt;
      min_out_r   <= min_out_nxt;
      min_vld_r   <= min_vld_nxt;
      min_empty_r <= min_empty_nxt;
    end
  end

  assign run_min   = run_min_r;
  assign min_out   = min_out_r;
  assign min_vld   = min_vld_r;
  assign min_empty = min_empty_r;

endmodule

// File: tb/tb_window_min_hold.sv
// Self-checking bench for window_min_hold with an 8-cycle window: directed
// table, corner-case sequences and random traffic against a queue-based model.
module tb_window_min_hold;

  localparam int DW = 9;
  localparam int WC = 8;
  localparam logic [DW-1:0] ONES = 9'h1FF;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] sample_in;
  logic          sample_vld;
  logic [DW-1:0] run_min;
  logic [DW-1:0] min_out;
  logic          min_vld;
  logic          min_empty;

  window_min_hold #(.DATA_W(DW), .WINDOW_CYCLES(WC), .CNT_W(32)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .enable     (enable),
    .sample_in  (sample_in),
    .sample_vld (sample_vld),
    .run_min    (run_min),
    .min_out    (min_out),
    .min_vld    (min_vld),
    .min_empty  (min_empty)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: samples of the open window kept as a plain list
  bit            m_active;
  int            m_pos;
  int            m_q[$];
  logic [DW-1:0] e_run_min;
  logic [DW-1:0] e_min_out;
  logic          e_vld;
  logic          e_empty;

  typedef struct {
    logic          en;
    logic          vld;
    logic [DW-1:0] smp;
    logic [DW-1:0] run_min;
    logic          vld_o;
    logic [DW-1:0] min_out;
    logic          empty;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int list_min();
    int m = 511;
    foreach (m_q[i]) if (m_q[i] < m) m = m_q[i];
    return m;
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_pos     = 0;
    m_q.delete();
    e_run_min = ONES;
    e_min_out = '0;
    e_vld     = 1'b0;
    e_empty   = 1'b1;
  endtask

  task automatic model_edge(input logic en, input logic vld, input logic [DW-1:0] smp);
    e_vld = 1'b0;
    if (!m_active) begin
      if (en) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_q.delete();
      end
    end else if (!en) begin
      m_active = 1'b0;
      m_q.delete();
    end else begin
      if (vld) m_q.push_back(int'(smp));
      if (m_pos == WC - 1) begin
        e_vld = 1'b1;
        if (m_q.size() > 0) begin
          e_min_out = DW'(list_min());
          e_empty   = 1'b0;
        end else begin
          e_empty = 1'b1;
        end
        m_q.delete();
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    e_run_min = DW'(list_min());
  endtask

  task automatic check_model();
    check("model run_min", run_min, e_run_min);
    check("model min_out", min_out, e_min_out);
    check("model min_vld", DW'(min_vld), DW'(e_vld));
    check("model min_empty", DW'(min_empty), DW'(e_empty));
  endtask

  // Apply one cycle of inputs, then compare just after the rising edge
  task automatic step(input logic en, input logic vld, input logic [DW-1:0] smp);
    enable     = en;
    sample_vld = vld;
    sample_in  = smp;
    @(posedge clock);
    #1;
    model_edge(en, vld, smp);
    check_model();
  endtask

  task automatic start_window();
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " run_min"}, run_min, ONES);
    check({tag, " min_out"}, min_out, 9'd0);
    check({tag, " min_vld"}, DW'(min_vld), 9'd0);
    check({tag, " min_empty"}, DW'(min_empty), 9'd1);
  endtask

  initial begin
    // Basic window: entry cycle, then cnt 0..7, then first cycle of next window
    tbl[0] = '{1'b1, 1'b0, 9'd0,  ONES,   1'b0, 9'd0,  1'b1};
    tbl[1] = '{1'b1, 1'b1, 9'd50, 9'd50,  1'b0, 9'd0,  1'b1};
    tbl[2] = '{1'b1, 1'b1, 9'd20, 9'd20,  1'b0, 9'd0,  1'b1};
    tbl[3] = '{1'b1, 1'b1, 9'd30, 9'd20,  1'b0, 9'd0,  1'b1};
    tbl[4] = '{1'b1, 1'b1, 9'd20, 9'd20,  1'b0, 9'd0,  1'b1};
    tbl[5] = '{1'b1, 1'b1, 9'd99, 9'd20,  1'b0, 9'd0,  1'b1};
    tbl[6] = '{1'b1, 1'b0, 9'd7,  9'd20,  1'b0, 9'd0,  1'b1};
    tbl[7] = '{1'b1, 1'b0, 9'd0,  9'd20,  1'b0, 9'd0,  1'b1};
    tbl[8] = '{1'b1, 1'b0, 9'd0,  ONES,   1'b1, 9'd20, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 9'd0,  ONES,   1'b0, 9'd20, 1'b0};

    rst_n      = 1'b0;
    enable     = 1'b0;
    sample_vld = 1'b0;
    sample_in  = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    #3 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].en, tbl[i].vld, tbl[i].smp);
      check($sformatf("tbl%0d run_min", i), run_min, tbl[i].run_min);
      check($sformatf("tbl%0d min_vld", i), DW'(min_vld), DW'(tbl[i].vld_o));
      check($sformatf("tbl%0d min_out", i), min_out, tbl[i].min_out);
      check($sformatf("tbl%0d min_empty", i), DW'(min_empty), DW'(tbl[i].empty));
    end

    // Sample only on the last cycle lowers the minimum
    start_window();
    step(1'b1, 1'b1, 9'd40);
    for (int i = 1; i < WC - 1; i++) step(1'b1, 1'b0, 9'd0);
    step(1'b1, 1'b1, 9'd5);
    check("last-cycle min_out", min_out, 9'd5);
    check("last-cycle min_vld", DW'(min_vld), 9'd1);
    check("last-cycle next run_min", run_min, ONES);

    // Empty window after a window with min 20: strobe, empty flag, value held
    start_window();
    step(1'b1, 1'b1, 9'd20);
    for (int i = 1; i < WC; i++) step(1'b1, 1'b0, 9'd0);
    check("prior min_out", min_out, 9'd20);
    for (int i = 0; i < WC; i++) step(1'b1, 1'b0, 9'd123);
    check("empty min_vld", DW'(min_vld), 9'd1);
    check("empty min_empty", DW'(min_empty), 9'd1);
    check("empty min_out held", min_out, 9'd20);

    // All-ones samples still count as a non-empty window
    for (int i = 0; i < WC; i++) step(1'b1, 1'b1, ONES);
    check("ones min_out", min_out, ONES);
    check("ones min_empty", DW'(min_empty), 9'd0);
    check("ones min_vld", DW'(min_vld), 9'd1);

    // Enable dropped at cnt 4 discards the window; re-enable runs a full window
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 9'(100 - 32 * i));
    check("pre-drop run_min", run_min, 9'd4);
    step(1'b0, 1'b1, 9'd1);
    check("drop min_vld", DW'(min_vld), 9'd0);
    check("drop min_out", min_out, ONES);
    check("drop run_min", run_min, ONES);
    step(1'b1, 1'b0, 9'd0);
    for (int i = 0; i < WC - 1; i++) begin
      step(1'b1, 1'b1, 9'(60 + i));
      check($sformatf("reenable no pulse %0d", i), DW'(min_vld), 9'd0);
    end
    step(1'b1, 1'b1, 9'd200);
    check("reenable pulse", DW'(min_vld), 9'd1);
    check("reenable min_out", min_out, 9'd60);

    // Enable dropped on the final window cycle: window discarded
    for (int i = 0; i < WC - 1; i++) step(1'b1, 1'b1, 9'd9);
    step(1'b0, 1'b1, 9'd2);
    check("final-drop min_vld", DW'(min_vld), 9'd0);
    check("final-drop min_out", min_out, 9'd60);

    // Async reset at cnt 5
    start_window();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 9'(30 + i));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    model_reset();
    @(posedge clock);
    #1;
    check_reset_outputs("held reset");
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, 9'd0);
    for (int i = 0; i < WC - 1; i++) begin
      step(1'b1, 1'b1, 9'(77 - i));
      check($sformatf("post-reset no pulse %0d", i), DW'(min_vld), 9'd0);
    end
    step(1'b1, 1'b0, 9'd0);
    check("post-reset pulse", DW'(min_vld), 9'd1);
    check("post-reset min_out", min_out, 9'd71);

    // Random traffic against the model
    begin
      int vld_pct = 60;
      for (int n = 0; n < 3000; n++) begin
        logic en, vld;
        logic [DW-1:0] smp;
        int r;
        if (n % 50 == 0) vld_pct = $urandom_range(0, 100);
        en  = ($urandom_range(0, 39) != 0);
        vld = ($urandom_range(1, 100) <= vld_pct);
        r   = $urandom_range(0, 9);
        if (r == 0) smp = '0;
        else if (r == 1) smp = ONES;
        else smp = DW'($urandom_range(0, 511));
        step(en, vld, smp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
